ow_bit_engine: RTL
==================

Name: ow_bit_engine

Overview:
- 1-Wire master bit-level timing engine.
- Sits directly upstream of the 1-Wire slave: its IO_PD drives the shared open-drain IO line that the slave's IOX samples, and it samples the slave's pull-downs through IO_IN.
- Executes one command at a time (reset/presence, write bit, read bit) with microsecond-accurate slot timing derived from the system clock.
- A byte/ROM-level sequencer feeds it over a valid/ready handshake.

Parameters:
- CLK_PER_US, 4, system clocks per microsecond (>=2)
- T_RSTL, 480, reset low time, us
- T_PDS, 70, presence sample point after reset release, us
- T_RSTH, 480, reset high (recovery) time after release, us
- T_W1L, 6, write-1 and read low time, us
- T_W0L, 60, write-0 low time, us
- T_RDS, 15, read sample point from slot start, us
- T_SLOT, 70, total slot length including recovery, us

Ports:
- CLK  input  1  system clock
- RSTZ  input  1  asynchronous active-low reset
- CMD_VALID  input  1  command request
- CMD_READY  output  1  engine idle, command accepted when VALID&READY
- CMD_TYPE  input  2  00 reset, 01 write bit, 10 read bit, 11 reserved
- CMD_WBIT  input  1  bit value for write
- DONE  output  1  one-cycle completion pulse
- RDATA  output  1  sampled read bit, valid from DONE until next DONE
- PRESENCE  output  1  presence detected by last reset
- SHORT  output  1  line still low at end of reset recovery
- IO_PD  output  1  1 = pull IO low (open-drain enable)
- IO_IN  input  1  asynchronous IO line level

Behaviour:
- Clock is CLK; reset is RSTZ, asynchronous and active-low.
- Reset values: CMD_READY=1, DONE=0, RDATA=0, PRESENCE=0, SHORT=0, IO_PD=0, state IDLE, counters 0.
- RSTZ assertion mid-command aborts immediately, releases IO_PD asynchronously, and produces no DONE.
- IO_IN passes through a 2-FF synchronizer; all samples use the synchronized value (2-cycle lag, accepted).
- Microsecond tick:
  - Prescaler counts 0..CLK_PER_US-1 and is cleared on accept.
  - One tick is generated per CLK_PER_US cycles.
  - US_CNT (10 bits) counts ticks since phase start.
- Handshake:
  - CMD_READY=1 only in IDLE.
  - Accept on the edge where CMD_VALID&CMD_READY; CMD_TYPE and CMD_WBIT are latched there.
  - CMD_VALID while busy is held off, with no drop and no queue.
- States: IDLE, RST_LOW, RST_HIGH, SLOT_LOW, SLOT_HIGH, FIN.
- Reset command:
  - On the accept edge, IO_PD goes 1 and the engine enters RST_LOW.
  - After T_RSTL*CLK_PER_US cycles: IO_PD=0, enter RST_HIGH, US_CNT cleared.
  - At US_CNT==T_PDS tick: PRESENCE = ~sync_io.
  - At US_CNT==T_RSTH: SHORT = ~sync_io, go to FIN.
- Write command:
  - IO_PD goes 1 at accept and stays 1 for T_W1L (bit=1) or T_W0L (bit=0) us, measured from accept. Then SLOT_HIGH.
  - Slot ends T_SLOT us after accept, then FIN.
- Read command:
  - IO_PD=1 for T_W1L us, then released.
  - At T_RDS us from accept: RDATA = sync_io.
  - Slot ends at T_SLOT us, then FIN.
- Reserved 11 is accepted, produces no IO activity, and pulses DONE one cycle after accept. No flags change.
- FIN lasts 1 cycle: DONE=1 and CMD_READY=1 in the same cycle, so back-to-back accept is allowed and the new command starts that edge.
- DONE cycle for slots is T_SLOT*CLK_PER_US cycles after the accept edge; for reset it is (T_RSTL+T_RSTH)*CLK_PER_US.
- Boundary cases:
  - If a low time is >= T_SLOT, the slot ends when the low phase ends; IO_PD releases in the FIN cycle.
  - PRESENCE and SHORT update only on reset commands.
  - RDATA updates only on read commands.

Decomposition:
- Package ow_pkg holds:
  - CMD_TYPE encodings (OW_CMD_RST, OW_CMD_WR, OW_CMD_RD)
  - state encoding constants
  - default timing constants
- One sub-module, ow_us_tick: the prescaler plus US_CNT with clear input.
- The synchronizer stays inline.

Test Plan:
- Reset with slave model present (CLK_PER_US=4) -> IO_PD high exactly 1920 cycles; PRESENCE=1, SHORT=0; DONE at cycle 3840 after accept; ROMID slave responds normally.
- Reset with no slave (IO pulled up only) -> PRESENCE=0, SHORT=0. With IO forced low throughout -> PRESENCE=1, SHORT=1.
- Write bit 0 then bit 1 back-to-back (VALID held) -> IO_PD widths 240 and 24 cycles; DONE at 280 and 560; second accept in the first DONE cycle.
- Read with slave driving 0, then driving 1 -> RDATA=0 then 1; IO_PD width 24 cycles; sample at cycle 60.
- RSTZ low at cycle 100 of a write-0 -> IO_PD=0 immediately, no DONE, CMD_READY=1 after release; next reset command behaves normally.
- CMD_TYPE=11 -> DONE one cycle after accept, IO_PD never asserted, flags unchanged.

Source files
------------

// File: rtl/ow_pkg.sv
// Shared encodings and default slot timing for the 1-Wire master bit engine.
package ow_pkg;

  typedef enum logic [1:0] {
    OW_CMD_RST = 2'b00,
    OW_CMD_WR  = 2'b01,
    OW_CMD_RD  = 2'b10,
    OW_CMD_RSV = 2'b11
  } ow_cmd_e;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StRstLow   = 3'd1,
    StRstHigh  = 3'd2,
    StSlotLow  = 3'd3,
    StSlotHigh = 3'd4,
    StFin      = 3'd5
  } ow_state_e;

  localparam int unsigned US_CNT_W       = 10;
  localparam int unsigned DEF_CLK_PER_US = 4;
  localparam int unsigned DEF_T_RSTL     = 480;
  localparam int unsigned DEF_T_PDS      = 70;
  localparam int unsigned DEF_T_RSTH     = 480;
  localparam int unsigned DEF_T_W1L      = 6;
  localparam int unsigned DEF_T_W0L      = 60;
  localparam int unsigned DEF_T_RDS      = 15;
  localparam int unsigned DEF_T_SLOT     = 70;

endpackage

// File: rtl/ow_us_tick.sv
// Microsecond prescaler and elapsed-microsecond counter, both cleared at phase start.
module ow_us_tick
  import ow_pkg::*;
#(
  parameter int unsigned CLK_PER_US = DEF_CLK_PER_US
) (
  input  logic                clk,
  input  logic                rstz,
  input  logic                clr,
  output logic                tick,
  output logic [US_CNT_W-1:0] us_cnt
);

  localparam int unsigned PW = $clog2(CLK_PER_US);
  localparam logic [PW-1:0] PrescMax = PW'(CLK_PER_US - 1);

  logic [PW-1:0]       presc_q;
  logic [US_CNT_W-1:0] us_cnt_q;

  assign tick   = (presc_q == PrescMax);
  assign us_cnt = us_cnt_q;

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      presc_q  <= '0;
      us_cnt_q <= '0;
    end else if (clr) begin
      presc_q  <= '0;
      us_cnt_q <= '0;
    end else begin
      presc_q <= tick ? '0 : presc_q + 1'b1;
      if (tick) begin
        us_cnt_q <= us_cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ow_bit_engine.sv
// 1-Wire master bit engine: reset/presence, write-bit and read-bit slots with
// microsecond timing, one command at a time over a valid/ready handshake.
module ow_bit_engine
  import ow_pkg::*;
#(
  parameter int unsigned CLK_PER_US = DEF_CLK_PER_US,
  parameter int unsigned T_RSTL     = DEF_T_RSTL,
  parameter int unsigned T_PDS      = DEF_T_PDS,
  parameter int unsigned T_RSTH     = DEF_T_RSTH,
  parameter int unsigned T_W1L      = DEF_T_W1L,
  parameter int unsigned T_W0L      = DEF_T_W0L,
  parameter int unsigned T_RDS      = DEF_T_RDS,
  parameter int unsigned T_SLOT     = DEF_T_SLOT
) (
  input  logic       clk,
  input  logic       rstz,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_type,
  input  logic       cmd_wbit,
  output logic       done,
  output logic       rdata,
  output logic       presence,
  output logic       short,
  output logic       io_pd,
  input  logic       io_in
);

  // A phase of N us ends on the tick that moves us_cnt from N-1 to N.
  localparam logic [US_CNT_W-1:0] RstlEnd = US_CNT_W'(T_RSTL - 1);
  localparam logic [US_CNT_W-1:0] PdsEnd  = US_CNT_W'(T_PDS - 1);
  localparam logic [US_CNT_W-1:0] RsthEnd = US_CNT_W'(T_RSTH - 1);
  localparam logic [US_CNT_W-1:0] W1lEnd  = US_CNT_W'(T_W1L - 1);
  localparam logic [US_CNT_W-1:0] W0lEnd  = US_CNT_W'(T_W0L - 1);
  localparam logic [US_CNT_W-1:0] RdsEnd  = US_CNT_W'(T_RDS - 1);
  localparam logic [US_CNT_W-1:0] SlotEnd = US_CNT_W'(T_SLOT - 1);
  localparam bit W1lGeSlot = (T_W1L >= T_SLOT);
  localparam bit W0lGeSlot = (T_W0L >= T_SLOT);

  ow_state_e state_q, state_d;
  ow_cmd_e   cmd_q, cmd_d, cmd_in;
  logic      wbit_q, wbit_d;
  logic      io_pd_q, io_pd_d;
  logic      rdata_q, rdata_d;
  logic      presence_q, presence_d;
  logic      short_q, short_d;
  logic      tick_clr, tick;
  logic [US_CNT_W-1:0] us_cnt;
  logic [1:0] sync_q;
  logic       sync_io;
  logic       accept, is_rd, long_low;
  logic       hit_rstl, hit_pds, hit_rsth, hit_low, hit_rds, hit_slot;
  logic [US_CNT_W-1:0] low_end;

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], io_in};
    end
  end
  assign sync_io = sync_q[1];

  ow_us_tick #(
    .CLK_PER_US(CLK_PER_US)
  ) u_us_tick (
    .clk   (clk),
    .rstz  (rstz),
    .clr   (tick_clr),
    .tick  (tick),
    .us_cnt(us_cnt)
  );

  assign cmd_ready = (state_q == StIdle) || (state_q == StFin);
  assign accept    = cmd_valid && cmd_ready;
  assign cmd_in    = ow_cmd_e'(cmd_type);
  assign is_rd     = (cmd_q == OW_CMD_RD);
  // Only a write-0 uses the long low time; write-1 and read share T_W1L.
  assign low_end   = (cmd_q == OW_CMD_WR && !wbit_q) ? W0lEnd : W1lEnd;
  assign long_low  = (cmd_q == OW_CMD_WR && !wbit_q) ? W0lGeSlot : W1lGeSlot;

  assign hit_rstl = tick && (us_cnt == RstlEnd);
  assign hit_pds  = tick && (us_cnt == PdsEnd);
  assign hit_rsth = tick && (us_cnt == RsthEnd);
  assign hit_low  = tick && (us_cnt == low_end);
  assign hit_rds  = tick && (us_cnt == RdsEnd);
  assign hit_slot = tick && (us_cnt == SlotEnd);

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    wbit_d     = wbit_q;
    io_pd_d    = io_pd_q;
    rdata_d    = rdata_q;
    presence_d = presence_q;
    short_d    = short_q;
    tick_clr   = 1'b0;
    unique case (state_q)
      StIdle, StFin: begin
        io_pd_d = 1'b0;
        state_d = StIdle;
        if (accept) begin
          cmd_d    = cmd_in;
          wbit_d   = cmd_wbit;
          tick_clr = 1'b1;
          unique case (cmd_in)
            OW_CMD_RST: begin
              io_pd_d = 1'b1;
              state_d = StRstLow;
            end
            OW_CMD_WR, OW_CMD_RD: begin
              io_pd_d = 1'b1;
              state_d = StSlotLow;
            end
            default: state_d = StFin;
          endcase
        end
      end
      StRstLow: begin
        if (hit_rstl) begin
          io_pd_d  = 1'b0;
          tick_clr = 1'b1;
          state_d  = StRstHigh;
        end
      end
      StRstHigh: begin
        if (hit_pds) begin
          presence_d = ~sync_io;
        end
        if (hit_rsth) begin
          short_d = ~sync_io;
          state_d = StFin;
        end
      end
      StSlotLow: begin
        if (is_rd && hit_rds) begin
          rdata_d = sync_io;
        end
        if (hit_low) begin
          io_pd_d = 1'b0;
          state_d = long_low ? StFin : StSlotHigh;
        end
      end
      StSlotHigh: begin
        if (is_rd && hit_rds) begin
          rdata_d = sync_io;
        end
        if (hit_slot) begin
          state_d = StFin;
        end
      end
      default: begin
        io_pd_d = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      state_q    <= StIdle;
      cmd_q      <= OW_CMD_RST;
      wbit_q     <= 1'b0;
      io_pd_q    <= 1'b0;
      rdata_q    <= 1'b0;
      presence_q <= 1'b0;
      short_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      wbit_q     <= wbit_d;
      io_pd_q    <= io_pd_d;
      rdata_q    <= rdata_d;
      presence_q <= presence_d;
      short_q    <= short_d;
    end
  end

  assign done     = (state_q == StFin);
  assign io_pd    = io_pd_q;
  assign rdata    = rdata_q;
  assign presence = presence_q;
  assign short    = short_q;

endmodule
